// File: rtl/alu_pkg.sv
// Shared ALU control codes and arbiter FSM state type.
// Used by the alu, the arbiter and the bench.
package alu_pkg;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_PASSB = 4'b0111;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   function automatic logic [1:0] onehot(input logic id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Two-requester ALU request/response bus.
// master = requester side, slave = arbiter side.
interface alu_arbiter_if #(
   parameter int N = 64
);
   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [1:0][N-1:0] req_a;
   logic [1:0][N-1:0] req_b;
   logic [1:0][3:0]   req_op;
   logic [1:0]        rsp_valid;
   logic [1:0]        rsp_ready;
   logic [N-1:0]      rsp_result;
   logic              rsp_zero;
   logic              busy;
   logic              grant_id;

   modport master (
      output req_valid, req_a, req_b, req_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_zero,
      input  busy, grant_id
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_zero,
      output busy, grant_id
   );

endinterface

// File: rtl/alu.sv
// Combinational ALU; unknown control codes yield all-ones.
// ADD/SUB wrap, no flags besides zero.
module alu
   import alu_pkg::*;
#(
   parameter int N = 64
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic [3:0]   op_i,
   output logic [N-1:0] result_o,
   output logic         zero_o
);

   always_comb begin
      result_o = '1;
      unique case (op_i)
         ALU_AND:   result_o = a_i & b_i;
         ALU_OR:    result_o = a_i | b_i;
         ALU_ADD:   result_o = a_i + b_i;
         ALU_SUB:   result_o = a_i - b_i;
         ALU_PASSB: result_o = b_i;
         default:   result_o = '1;
      endcase
   end

   assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between two requesters.
// One op in flight: IDLE -> EXEC -> RESP -> IDLE.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int N = 64
) (
   input  logic      clk,
   input  logic      reset,
   alu_arbiter_if.slave bus
);

   state_t       state_q;
   logic         last_q;
   logic         gid_q;
   logic [N-1:0] a_q;
   logic [N-1:0] b_q;
   logic [3:0]   op_q;
   logic [N-1:0] res_q;
   logic         zero_q;
   logic [1:0]   rv_q;

   logic [N-1:0] alu_res;
   logic         alu_zero;
   logic         win;
   logic         any_req;

   // Tie goes to whoever did not win last time.
   assign any_req = |bus.req_valid;
   assign win = (bus.req_valid == 2'b11) ? ~last_q
              : bus.req_valid[1];

   alu #(.N(N)) u_alu (
      .a_i      (a_q),
      .b_i      (b_q),
      .op_i     (op_q),
      .result_o (alu_res),
      .zero_o   (alu_zero)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         gid_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         rv_q    <= 2'b00;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (any_req) begin
                  a_q     <= bus.req_a[win];
                  b_q     <= bus.req_b[win];
                  op_q    <= bus.req_op[win];
                  gid_q   <= win;
                  last_q  <= win;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               res_q   <= alu_res;
               zero_q  <= alu_zero;
               rv_q    <= onehot(gid_q);
               state_q <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready[gid_q]) begin
                  rv_q    <= 2'b00;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = (reset && state_q == IDLE && any_req)
                        ? onehot(win) : 2'b00;
   assign bus.rsp_valid  = rv_q;
   assign bus.rsp_result = res_q;
   assign bus.rsp_zero   = zero_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.grant_id   = gid_q;

endmodule
